// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buffer_if.sv
// Instruction-memory request/grant/response bus plus the instruction
// valid/ready handshake toward the IF/ID register.
interface ifetch_buffer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with async reset and a
// synchronous flush that wins over push and pop.
module instr_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch buffer: credit-limited sequential fetch, in-order
// response queueing, and flush/restart on redirect with stale-response discard.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  ifetch_buffer_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_flight;
  logic          fifo_full, fifo_empty;
  logic          grant, keep, drop, push, pop;
  logic [31:0]   target;
  fetch_entry_t  push_entry, head;

  assign target    = redirect_pc & 32'hFFFF_FFFC;
  assign in_flight = {1'b0, fifo_count} + {1'b0, live_q};

  assign bus.imem_req  = !reset && !redirect && (in_flight < CREDIT_LIMIT);
  assign bus.imem_addr = fetch_pc_q;

  assign grant      = bus.imem_req && bus.imem_gnt;
  assign drop       = bus.imem_rvalid && (discard_q != '0);
  assign keep       = bus.imem_rvalid && (discard_q == '0) && !redirect;
  assign push       = keep && !fifo_full;
  assign pop        = !fifo_empty && bus.instr_ready && !redirect;
  assign push_entry = '{pc: resp_pc_q, instr: bus.imem_rdata};

  // In a redirect cycle every arriving response is stale, whether it was
  // already marked for discard or was still live, so it retires one credit.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      live_d     = '0;
      discard_d  = discard_q + live_q - CW'(bus.imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (keep)  resp_pc_d  = resp_pc_q + PC_STEP;
      if (drop)  discard_d  = discard_q - CW'(1);
      live_d = live_q + CW'(grant) - CW'(keep);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.instr_pc    = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: doc/ifetch_buffer.md
# ifetch_buffer

Instruction prefetch buffer placed directly upstream of the pipeline's IF stage. It issues sequential word fetches to instruction memory over a request/grant/response bus and queues the returned words with their PCs in a small FIFO. It presents one instruction per cycle to the IF/ID register under a valid/ready handshake. On a taken branch or jump it flushes its contents and restarts fetching at the redirect target.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries and credit limit. Power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: the only clock. Rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `redirect` in 1: flush and restart. Driven by PCSrcE.
- `redirect_pc` in 32: restart address. Driven by PCTargetE; bits [1:0] are ignored.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_gnt` in 1: request accepted this cycle (`imem_req & imem_gnt`).
- `imem_rvalid` in 1: response valid. Responses are in order, no earlier than the cycle after grant.
- `imem_rdata` in 32: response instruction word.
- `instr_valid` out 1: head entry is valid.
- `instr` out 32: head instruction. Equals NOP 32'h0000_0013 when `instr_valid` is 0.
- `instr_pc` out 32: head PC. Equals 0 when `instr_valid` is 0.
- `instr_ready` in 1: consumer takes the head this cycle. Driven by ~StallF.

## Operation

State:
- `fetch_pc`: next request address.
- `resp_pc`: PC of the next live response.
- FIFO of {pc, instr} with occupancy `count`.
- `live`: outstanding granted requests whose responses are kept.
- `discard`: outstanding granted requests whose responses are dropped.
- Counter widths are $clog2(DEPTH+1).

Issue:
- `imem_req` = !redirect && (count + live < DEPTH). The credit check uses registered values only.
- `imem_addr` = `fetch_pc`.
- A grant increments `live` and advances `fetch_pc` by 4.

Response:
- If `discard` > 0, a response is dropped and decrements `discard`.
- Otherwise it pushes {`resp_pc`, `imem_rdata`}, decrements `live`, and advances `resp_pc` by 4.
- The credit rule guarantees a push never hits a full FIFO.

Pop:
- `instr_valid && instr_ready` removes the head.
- A push and a pop in the same cycle leave `count` unchanged.

Redirect (has priority over everything else in its cycle):
- FIFO cleared (`count` = 0). Any pop in that cycle is ignored.
- `discard` <= `discard` + `live` - (1 if a dropped response arrives this cycle).
- A live response arriving in the redirect cycle is dropped and counted.
- `live` <= 0.
- `fetch_pc` and `resp_pc` <= {redirect_pc[31:2], 2'b00}.
- No request is issued in the redirect cycle.

Arithmetic:
- PCs wrap modulo 2^32. Address 32'hFFFF_FFFC is followed by 0.

## Timing

Reset values (asserted asynchronously, immediately):
- `fetch_pc` = `resp_pc` = RESET_PC.
- `count`, `live`, `discard` = 0.
- `instr_valid` = 0, `instr` = NOP, `instr_pc` = 0.
- `imem_req` rises combinationally once reset is released.
- Reset asserted mid-stream discards all state. Responses to pre-reset requests must not reach the bus after reset; the memory is reset together with this block.

Latency:
- Response accepted at the edge ending cycle N → `instr_valid` in cycle N+1. There is no combinational rdata-to-instr bypass.
- Redirect in cycle R → first request in R+1. With grant in R+1 and rvalid in R+2, the target instruction is valid in R+3.

Throughput:
- With `imem_gnt` held 1, one-cycle response, and DEPTH ≥ 3, the block delivers one instruction per cycle in steady state.

All outputs except `imem_req` are driven from registers.

## Structure

- `ifetch_pkg`: `NOP_INSTR` (32'h0000_0013), `fetch_entry_t` packed struct {pc[31:0], instr[31:0]}, and `PC_STEP` (4).
- Sub-module `instr_fifo`:
  - Synchronous FIFO of `fetch_entry_t` with async active-high reset and a synchronous `flush`.
  - Signals: push/pop/full/empty/count.
  - Pointers wrap modulo DEPTH.
- Credit, discard, and PC logic stay in `ifetch_buffer`.

## Test plan

- **Reset:** assert `reset` mid-run → outputs return to reset values in the same cycle with no clock edge. After release: `imem_req`=1, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0x13.
- **Streaming:** `imem_gnt`=1, rvalid one cycle after grant with rdata=addr^32'hA5A5_0000, `instr_ready`=1 → `instr_pc` = 0,4,8,… on consecutive cycles from cycle 3, and `instr` matches.
- **Backpressure:** `instr_ready`=0 → `imem_req` drops once count+live=4, and exactly 4 entries are held. Then `instr_ready`=1 → PCs 0,4,8,C,10… with no gap, loss, or duplicate.
- **Redirect with stale responses:** redirect to 0x100 with 2 live requests outstanding → both stale responses are dropped, no request in the redirect cycle, next `imem_addr`=0x100, and the first delivered `instr_pc`=0x100.
- **Misaligned redirect and pop:** redirect to 0x102 while `instr_valid`=`instr_ready`=1 and a response arrives → FIFO is empty next cycle, that response is dropped, and fetch restarts at 0x100.
- **Wrap-around:** RESET_PC=32'hFFFF_FFF8, streaming → `instr_pc` = FFFF_FFF8, FFFF_FFFC, 0000_0000.
